// File: rtl/psum_quant.sv
// Partial-sum accumulator and int8 requantizer for the conv MAC array.
// Two pipeline stages follow the accumulator: a sum register, then round/relu/saturate.
module psum_quant #(
    parameter int IN_W  = 21,
    parameter int SUM_W = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_i,
    input  logic [IN_W-1:0] acc_i,
    input  logic [3:0]      cfg_grp,
    input  logic [3:0]      cfg_shift,
    input  logic            cfg_relu,
    input  logic [15:0]     bias_i,
    output logic [7:0]      dout,
    output logic            vld_o,
    output logic            sat_o,
    output logic            busy
);

    localparam logic signed [SUM_W:0] MAX_V = 127;
    localparam logic signed [SUM_W:0] MIN_V = -128;

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] grp_q, grp_d;
    logic [3:0] shift_q, shift_d;
    logic       relu_q, relu_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;

    logic                    s1_vld_q, s1_vld_d;
    logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic [3:0]              s1_shift_q, s1_shift_d;
    logic                    s1_relu_q, s1_relu_d;

    logic [7:0] dout_q, dout_d;
    logic       sat_q, sat_d;
    logic       vld_o_q, vld_o_d;

    logic                    first, last;
    logic [3:0]              grp_cfg, grp_cur, shift_cur;
    logic                    relu_cur;
    logic signed [SUM_W-1:0] acc_ext, bias_ext, sum_nxt;
    logic signed [SUM_W:0]   half, rnd, r;

    // Config is taken live on the first beat and from the held copy afterwards.
    always_comb begin
        first     = (cnt_q == 4'd0);
        grp_cfg   = (cfg_grp == 4'd0) ? 4'd1 : cfg_grp;
        grp_cur   = first ? grp_cfg : grp_q;
        shift_cur = first ? cfg_shift : shift_q;
        relu_cur  = first ? cfg_relu : relu_q;
        acc_ext   = {{(SUM_W-IN_W){acc_i[IN_W-1]}}, acc_i};
        bias_ext  = {{(SUM_W-16){bias_i[15]}}, bias_i};
        sum_nxt   = first ? (acc_ext + bias_ext) : (sum_q + acc_ext);
        last      = (cnt_q == grp_cur - 4'd1);

        cnt_d      = cnt_q;
        grp_d      = grp_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        sum_d      = sum_q;
        s1_vld_d   = 1'b0;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        s1_relu_d  = s1_relu_q;

        if (vld_i) begin
            sum_d = sum_nxt;
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
            if (first) begin
                grp_d   = grp_cfg;
                shift_d = cfg_shift;
                relu_d  = cfg_relu;
            end
            if (last) begin
                s1_vld_d   = 1'b1;
                s1_sum_d   = sum_nxt;
                s1_shift_d = shift_cur;
                s1_relu_d  = relu_cur;
            end
        end
    end

    // Round half up, then relu, then clip to int8.
    always_comb begin
        half = '0;
        if (s1_shift_q != 4'd0) begin
            half = (SUM_W+1)'(1) << (s1_shift_q - 4'd1);
        end
        rnd = {s1_sum_q[SUM_W-1], s1_sum_q} + half;
        r   = rnd >>> s1_shift_q;

        vld_o_d = s1_vld_q;
        dout_d  = dout_q;
        sat_d   = sat_q;
        if (s1_vld_q) begin
            if (s1_relu_q && (r < 0)) begin
                dout_d = 8'd0;
                sat_d  = 1'b0;
            end else if (r > MAX_V) begin
                dout_d = 8'd127;
                sat_d  = 1'b1;
            end else if (r < MIN_V) begin
                dout_d = 8'h80;
                sat_d  = 1'b1;
            end else begin
                dout_d = r[7:0];
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            grp_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            sum_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_relu_q  <= 1'b0;
            dout_q     <= '0;
            sat_q      <= 1'b0;
            vld_o_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            grp_q      <= grp_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            sum_q      <= sum_d;
            s1_vld_q   <= s1_vld_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            s1_relu_q  <= s1_relu_d;
            dout_q     <= dout_d;
            sat_q      <= sat_d;
            vld_o_q    <= vld_o_d;
        end
    end

    assign dout  = dout_q;
    assign sat_o = sat_q;
    assign vld_o = vld_o_q;
    assign busy  = (cnt_q != 4'd0);

endmodule

// File: tb/tb_psum_quant.sv
// Scoreboard bench for psum_quant: expected {dout, sat_o} queued at the final beat.
module tb_psum_quant;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_i;
    logic [20:0] acc_i;
    logic [3:0]  cfg_grp;
    logic [3:0]  cfg_shift;
    logic        cfg_relu;
    logic [15:0] bias_i;
    logic [7:0]  dout;
    logic        vld_o;
    logic        sat_o;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [8:0] sb[$];
    int vld_cyc[$];

    psum_quant dut (
        .clk(clk), .rst(rst), .vld_i(vld_i), .acc_i(acc_i),
        .cfg_grp(cfg_grp), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .bias_i(bias_i), .dout(dout), .vld_o(vld_o), .sat_o(sat_o),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_o === 1'b1) begin
            logic [8:0] exp_v;
            vld_cyc.push_back(cyc);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL spurious_vld dout=%0d sat=%0b expected no output",
                         $signed(dout), sat_o);
            end else begin
                exp_v = sb.pop_front();
                if ({dout, sat_o} !== exp_v) begin
                    fails++;
                    $display("FAIL pixel dout=%0d sat=%0b expected dout=%0d sat=%0b",
                             $signed(dout), sat_o, $signed(exp_v[8:1]), exp_v[0]);
                end
            end
        end
    end

    function automatic logic [8:0] model(longint s, int sh, bit relu);
        longint r;
        r = (sh > 0) ? ((s + (longint'(1) << (sh - 1))) >>> sh) : s;
        if (relu && r < 0) return 9'd0;
        if (r > 127) return {8'd127, 1'b1};
        if (r < -128) return {8'h80, 1'b1};
        return {r[7:0], 1'b0};
    endfunction

    task automatic beat(input logic [20:0] a);
        vld_i = 1'b1;
        acc_i = a;
        @(posedge clk);
        #1;
        vld_i = 1'b0;
    endtask

    task automatic setcfg(input int g, input int sh, input bit rl, input int b);
        cfg_grp   = 4'(g);
        cfg_shift = 4'(sh);
        cfg_relu  = rl;
        bias_i    = 16'(b);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vld_i = 1'b0;
        acc_i = '0;
        setcfg(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({dout, vld_o, sat_o, busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_state dout=%0h vld=%0b sat=%0b busy=%0b expected all 0",
                     dout, vld_o, sat_o, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        setcfg(1, 0, 0, 0);
        sb.push_back({8'd100, 1'b0});
        beat(100);
        tests++;
        if (vld_o !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL latency_early vld=%0b busy=%0b expected 0 0", vld_o, busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (vld_o !== 1'b1 || dout !== 8'd100) begin
            fails++;
            $display("FAIL latency2 vld=%0b dout=%0d expected 1 100", vld_o, dout);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_single left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_spec_vectors;
        setcfg(3, 4, 0, 10);
        sb.push_back({8'd127, 1'b1});
        beat(1000);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_mid busy=%0b expected 1", busy);
        end
        beat(2000);
        beat(-500);
        setcfg(2, 0, 1, 0);
        sb.push_back({8'd0, 1'b0});
        beat(-300);
        beat(-50);
        setcfg(2, 0, 0, 0);
        sb.push_back({8'h80, 1'b1});
        beat(-300);
        beat(-50);
        setcfg(1, 4, 0, 0);
        sb.push_back({8'd2, 1'b0});
        beat(24);
        sb.push_back({8'hFF, 1'b0});
        beat(-24);
        sb.push_back({8'hFE, 1'b0});
        beat(-25);
        setcfg(0, 0, 0, -3);
        sb.push_back({8'd4, 1'b0});
        beat(7);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL grp0_busy busy=%0b expected 0", busy);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_vectors left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_mid_reset;
        setcfg(4, 0, 0, 0);
        beat(1);
        beat(2);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_partial busy=%0b expected 1", busy);
        end
        rst = 1'b1;
        vld_i = 1'b1;
        acc_i = 21'd77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vld_i = 1'b0;
        tests++;
        if (busy !== 1'b0 || vld_o !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_rst busy=%0b vld=%0b expected 0 0", busy, vld_o);
        end
        setcfg(1, 0, 0, 0);
        beat(50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back({8'd5, 1'b0});
        beat(5);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_reset left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = vld_cyc.size();
        setcfg(1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            sb.push_back({8'(k), 1'b0});
            beat(21'(k));
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (vld_cyc.size() - base != 3) begin
            fails++;
            $display("FAIL b2b_count got=%0d expected 3", vld_cyc.size() - base);
        end else if (vld_cyc[base+1] != vld_cyc[base] + 1 ||
                     vld_cyc[base+2] != vld_cyc[base] + 2) begin
            fails++;
            $display("FAIL b2b_consecutive cycles=%0d,%0d,%0d expected consecutive",
                     vld_cyc[base], vld_cyc[base+1], vld_cyc[base+2]);
        end
        setcfg(3, 0, 0, 1);
        sb.push_back({8'd12, 1'b0});
        beat(7);
        setcfg(1, 5, 1, 99);
        repeat (3) @(posedge clk);
        #1;
        beat(8);
        repeat (2) @(posedge clk);
        #1;
        beat(-4);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_gapped left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_random;
        for (int p = 0; p < 40; p++) begin
            int g, sh, n;
            bit rl;
            logic signed [15:0] b;
            longint s;
            g  = $urandom_range(0, 15);
            sh = $urandom_range(0, 15);
            rl = 1'($urandom_range(0, 1));
            b  = 16'($urandom);
            n  = (g == 0) ? 1 : g;
            setcfg(g, sh, rl, int'(b));
            s = longint'(b);
            for (int k = 0; k < n; k++) begin
                logic signed [20:0] a;
                a = (p < 4) ? ((p % 2) ? -21'sd1048576 : 21'sd1048575)
                            : 21'($urandom);
                s += longint'(a);
                if (k == n - 1) sb.push_back(model(s, sh, rl));
                beat(a);
                if (k == 0) setcfg(15, 15, ~rl, 16'h7fff);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_random left=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_spec_vectors;
        test_mid_reset;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_quant.md
PSUM_QUANT -- requirements
Module: psum_quant

Interface
REQ-001 Parameter IN_W, 21, width of the signed partial-sum input from the MAC array.
REQ-002 Parameter SUM_W, 26, width of the internal signed accumulator (IN_W + 4 + 1).
REQ-003 clk  input  1  rising-edge clock; the only clock of the block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 vld_i  input  1  partial-sum valid strobe from the MAC array; no backpressure exists.
REQ-006 acc_i  input  IN_W  signed two's-complement partial sum of one 27-tap group.
REQ-007 cfg_grp  input  4  number of partial sums per output pixel, 1..15; value 0 SHALL be treated as 1.
REQ-008 cfg_shift  input  4  right-shift amount for requantization, 0..15.
REQ-009 cfg_relu  input  1  1 = clamp negative results to 0 before saturation.
REQ-010 bias_i  input  16  signed bias added once per output pixel.
REQ-011 dout  output  8  signed requantized output pixel.
REQ-012 vld_o  output  1  single-cycle strobe marking dout valid.
REQ-013 sat_o  output  1  high with vld_o when the result was clipped to the int8 range.
REQ-014 busy  output  1  high while a pixel is partially accumulated (group counter nonzero).

Function
REQ-015 cfg_grp, cfg_shift, cfg_relu and bias_i SHALL be sampled on the first beat of a pixel (vld_i=1 with counter=0) and held internally until that pixel's output.
REQ-016 The first beat SHALL load sum = sext(acc_i) + sext(bias_i); each later beat SHALL perform sum = sum + sext(acc_i).
REQ-017 The group counter SHALL increment on each beat and return to 0 on the beat where counter = grp-1 (the final beat).
REQ-018 Cycles with vld_i=0 SHALL hold the sum and counter unchanged; gaps between beats of a pixel have unbounded length.
REQ-019 Stage 1: in the cycle after the final beat, a register SHALL hold the complete sum with a stage-1 valid flag.
REQ-020 Stage 2: rounding SHALL be r = (sum + 2^(shift-1)) >>> shift (arithmetic) for shift>0, and r = sum for shift=0.
REQ-021 If relu=1 and r<0, r SHALL become 0 and sat_o SHALL be 0 for that pixel.
REQ-022 r SHALL saturate to [-128, 127]; sat_o SHALL be 1 exactly when this clip changes the value.
REQ-023 dout, sat_o and vld_o SHALL be registered; vld_o SHALL assert for one cycle, two cycles after the final beat was sampled (latency 2).
REQ-024 The first beat of the next pixel may arrive in the cycle directly after a final beat; full throughput of one beat per cycle SHALL be sustained with no lost or merged pixels.
REQ-025 When cfg_grp resolves to 1, every beat SHALL be both first and final beat; busy stays 0.
REQ-026 dout and sat_o SHALL hold their last values while vld_o=0.
REQ-027 Internal arithmetic SHALL NOT overflow for 15 beats of full-scale IN_W inputs plus full-scale bias.

Reset
REQ-028 On rst=1 at a rising edge: counter=0, sum=0, stage-1 valid=0, dout=0, vld_o=0, sat_o=0, busy=0.
REQ-029 rst asserted mid-pixel SHALL discard the partial sum and any in-flight stage-1/stage-2 result; no vld_o SHALL follow for that pixel.
REQ-030 vld_i sampled in a cycle with rst=1 SHALL be ignored.

Verification
REQ-031 grp=1, shift=0, relu=0, bias=0, acc_i=100 -> vld_o 2 cycles later, dout=100, sat_o=0.
REQ-032 grp=3, bias=10, shift=4, beats 1000, 2000, -500 -> sum 2510, r=157 -> dout=127, sat_o=1.
REQ-033 grp=2, relu=1, shift=0, bias=0, beats -300, -50 -> dout=0, sat_o=0; same with relu=0 -> dout=-128, sat_o=1.
REQ-034 Rounding with grp=1, shift=4, bias=0: acc_i=24 -> dout=2; acc_i=-24 -> dout=-1; acc_i=-25 -> dout=-2.
REQ-035 grp=4, two beats then rst pulse, then grp=1 acc_i=5 -> exactly one vld_o with dout=5; busy 0 after reset.
REQ-036 grp=1, acc_i 1,2,3 on consecutive cycles, with gaps of vld_i=0 also tested for grp=3 -> vld_o on 3 consecutive cycles with dout 1,2,3; the gapped grp=3 pixel outputs the correct sum.
